// File: rtl/comm_pkg.sv
// Shared handshake definitions for the CPU-side sender and the peripheral receiver.
package comm_pkg;

    // Four-phase handshake encodings on send/ack
    localparam logic [1:0] HS_IDLE = 2'b00;
    localparam logic [1:0] HS_REQ  = 2'b01;

    // Receiver handshake states
    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } rx_state_t;

endpackage : comm_pkg

// File: rtl/rx_fifo.sv
// Small show-ahead FIFO: power-of-two depth, registered count, head gated to 0 when empty.
module rx_fifo #(
    parameter int unsigned DATA_W = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       valid_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok_c;
    logic              pop_ok_c;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign valid_o   = (count_q != '0);
    assign push_ok_c = push_i && !full_o;
    assign pop_ok_c  = pop_i && valid_o;
    assign rdata_o   = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o   = count_q;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because the head is gated when empty
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule : rx_fifo

// File: rtl/periph_rx_buffer.sv
// Peripheral side of the send/ack handshake: synchronizes send, captures dadoT into a FIFO,
// and presents queued items as a valid/ready stream.
module periph_rx_buffer
    import comm_pkg::*;
#(
    parameter int unsigned DATA_W      = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 send,
    input  logic [DATA_W-1:0]          dadoT,
    output logic [1:0]                 ack,
    output logic [DATA_W-1:0]          dado_out,
    output logic                       dado_valid,
    input  logic                       dado_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       proto_err
);

    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [1:0]                  send_s;
    logic                        req_s;
    logic                        err_s;

    rx_state_t  state_q, state_d;
    logic [1:0] ack_q, ack_d;
    logic       proto_err_q, proto_err_d;
    logic       push_c;
    logic       full_c;

    // Multi-flop synchronizer on both send bits; decisions only use the last stage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], send};
        end
    end

    assign send_s = sync_q[SYNC_STAGES-1];
    assign req_s  = (send_s == HS_REQ);
    assign err_s  = send_s[1];

    // Handshake state, registered ack and sticky protocol error
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ack_q       <= HS_IDLE;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Next state: capture once per request, hold off while full, re-arm when request drops
    always_comb begin
        state_d     = state_q;
        push_c      = 1'b0;
        ack_d       = HS_IDLE;
        proto_err_d = proto_err_q | err_s;
        case (state_q)
            IDLE: begin
                if (req_s && !full_c) begin
                    push_c  = 1'b1;
                    state_d = ACKED;
                end
            end
            ACKED: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == ACKED) begin
            ack_d = HS_REQ;
        end
    end

    rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rx_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .push_i  (push_c),
        .wdata_i (dadoT),
        .pop_i   (dado_ready),
        .rdata_o (dado_out),
        .valid_o (dado_valid),
        .full_o  (full_c),
        .count_o (count)
    );

    assign ack       = ack_q;
    assign proto_err = proto_err_q;

endmodule : periph_rx_buffer

// File: tb/tb_periph_rx_buffer.sv
// Directed self-checking bench for periph_rx_buffer.
module tb_periph_rx_buffer;

    logic       clock;
    logic       reset;
    logic [1:0] send;
    logic [1:0] dadoT;
    logic [1:0] ack;
    logic [1:0] dado_out;
    logic       dado_valid;
    logic       dado_ready;
    logic [2:0] count;
    logic       proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] mon_q [$];
    logic       mon_en  = 1'b0;
    logic [2:0] max_cnt = '0;

    periph_rx_buffer #(
        .DATA_W      (2),
        .DEPTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .send       (send),
        .dadoT      (dadoT),
        .ack        (ack),
        .dado_out   (dado_out),
        .dado_valid (dado_valid),
        .dado_ready (dado_ready),
        .count      (count),
        .proto_err  (proto_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Consumer-side monitor for the streaming scenario
    always @(posedge clock) begin
        if (mon_en) begin
            if (dado_valid && dado_ready) mon_q.push_back(dado_out);
            if (count > max_cnt) max_cnt <= count;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full four-phase transfer with bounded waits; ok=0 if either phase times out
    task automatic send_item(input logic [1:0] d, output bit ok);
        int n;
        ok    = 1'b1;
        dadoT = d;
        send  = 2'b01;
        n     = 0;
        do begin tick(); n++; end while (ack !== 2'b01 && n < 20);
        if (ack !== 2'b01) ok = 1'b0;
        send = 2'b00;
        n    = 0;
        do begin tick(); n++; end while (ack !== 2'b00 && n < 20);
        if (ack !== 2'b00) ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; send = 2'b00; dadoT = 2'b00; dado_ready = 1'b0;
        tick(); tick();
        n_tests++; if (ack !== 2'b00)     begin n_fail++; $display("FAIL reset_ack got=%b exp=00", ack); end
        n_tests++; if (dado_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", dado_valid); end
        n_tests++; if (dado_out !== 2'b00) begin n_fail++; $display("FAIL reset_dout got=%b exp=00", dado_out); end
        n_tests++; if (count !== 3'd0)     begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr got=%b exp=0", proto_err); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        dadoT = 2'b10; send = 2'b01;
        tick(); tick();
        n_tests++; if (ack !== 2'b00) begin n_fail++; $display("FAIL single_ack_early got=%b exp=00", ack); end
        tick();
        n_tests++; if (ack !== 2'b01)       begin n_fail++; $display("FAIL single_ack got=%b exp=01", ack); end
        n_tests++; if (dado_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", dado_valid); end
        n_tests++; if (dado_out !== 2'b10)  begin n_fail++; $display("FAIL single_dout got=%b exp=10", dado_out); end
        n_tests++; if (count !== 3'd1)      begin n_fail++; $display("FAIL single_count got=%0d exp=1", count); end
        send = 2'b00;
        tick(); tick();
        n_tests++; if (ack !== 2'b01) begin n_fail++; $display("FAIL single_ack_hold got=%b exp=01", ack); end
        tick();
        n_tests++; if (ack !== 2'b00) begin n_fail++; $display("FAIL single_ack_drop got=%b exp=00", ack); end
        dado_ready = 1'b1; tick(); dado_ready = 1'b0;
        n_tests++; if (count !== 3'd0)     begin n_fail++; $display("FAIL single_drain_count got=%0d exp=0", count); end
        n_tests++; if (dado_out !== 2'b00) begin n_fail++; $display("FAIL single_empty_dout got=%b exp=00", dado_out); end
    endtask

    task automatic test_fill();
        logic [1:0] items [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [1:0] drain [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
        bit ok;
        int n;
        dado_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_item(items[i], ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL fill_xfer%0d got=timeout exp=ack", i); end
        end
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got=%0d exp=4", count); end
        dadoT = 2'd1; send = 2'b01;
        for (int i = 0; i < 6; i++) tick();
        n_tests++; if (ack !== 2'b00)     begin n_fail++; $display("FAIL fill_backpressure_ack got=%b exp=00", ack); end
        n_tests++; if (count !== 3'd4)    begin n_fail++; $display("FAIL fill_backpressure_count got=%0d exp=4", count); end
        n_tests++; if (dado_out !== 2'd0) begin n_fail++; $display("FAIL fill_head got=%0d exp=0", dado_out); end
        dado_ready = 1'b1; tick(); dado_ready = 1'b0;
        n_tests++; if (dado_out !== 2'd1) begin n_fail++; $display("FAIL fill_pop_head got=%0d exp=1", dado_out); end
        n_tests++; if (count !== 3'd3)    begin n_fail++; $display("FAIL fill_pop_count got=%0d exp=3", count); end
        tick();
        n_tests++; if (ack !== 2'b01)  begin n_fail++; $display("FAIL fill_fifth_ack got=%b exp=01", ack); end
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_fifth_count got=%0d exp=4", count); end
        send = 2'b00;
        n = 0;
        do begin tick(); n++; end while (ack !== 2'b00 && n < 20);
        n_tests++; if (ack !== 2'b00) begin n_fail++; $display("FAIL fill_release got=%b exp=00", ack); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (dado_valid !== 1'b1 || dado_out !== drain[i]) begin
                n_fail++; $display("FAIL fill_drain%0d got=%0d/v%b exp=%0d/v1", i, dado_out, dado_valid, drain[i]);
            end
            dado_ready = 1'b1; tick(); dado_ready = 1'b0;
        end
        n_tests++; if (dado_valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty got=%b exp=0", dado_valid); end
    endtask

    task automatic test_streaming();
        logic [1:0] items [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
        bit ok;
        mon_q.delete();
        max_cnt = '0;
        dado_ready = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_item(items[i], ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL stream_xfer%0d got=timeout exp=ack", i); end
        end
        tick(); tick();
        mon_en = 1'b0;
        dado_ready = 1'b0;
        n_tests++; if (mon_q.size() != 4) begin n_fail++; $display("FAIL stream_size got=%0d exp=4", mon_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < mon_q.size()) begin
                n_tests++;
                if (mon_q[i] !== items[i]) begin n_fail++; $display("FAIL stream_item%0d got=%0d exp=%0d", i, mon_q[i], items[i]); end
            end
        end
        n_tests++; if (max_cnt > 3'd1) begin n_fail++; $display("FAIL stream_maxcount got=%0d exp<=1", max_cnt); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL stream_count got=%0d exp=0", count); end
    endtask

    task automatic test_push_pop();
        bit ok;
        int n;
        dado_ready = 1'b0;
        send_item(2'd2, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL pp_xfer0 got=timeout exp=ack"); end
        send_item(2'd3, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL pp_xfer1 got=timeout exp=ack"); end
        n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL pp_pre_count got=%0d exp=2", count); end
        dadoT = 2'd1; send = 2'b01;
        tick(); tick();
        dado_ready = 1'b1;
        tick();
        dado_ready = 1'b0;
        n_tests++; if (ack !== 2'b01)     begin n_fail++; $display("FAIL pp_ack got=%b exp=01", ack); end
        n_tests++; if (count !== 3'd2)    begin n_fail++; $display("FAIL pp_count got=%0d exp=2", count); end
        n_tests++; if (dado_out !== 2'd3) begin n_fail++; $display("FAIL pp_head got=%0d exp=3", dado_out); end
        send = 2'b00;
        n = 0;
        do begin tick(); n++; end while (ack !== 2'b00 && n < 20);
        dado_ready = 1'b1; tick(); dado_ready = 1'b0;
        n_tests++; if (dado_out !== 2'd1) begin n_fail++; $display("FAIL pp_second got=%0d exp=1", dado_out); end
        dado_ready = 1'b1; tick(); dado_ready = 1'b0;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL pp_drained got=%0d exp=0", count); end
    endtask

    task automatic test_proto_err();
        dadoT = 2'd2; send = 2'b10;
        tick(); tick();
        n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL perr_early got=%b exp=0", proto_err); end
        tick();
        n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_set got=%b exp=1", proto_err); end
        for (int i = 0; i < 3; i++) tick();
        n_tests++; if (ack !== 2'b00)  begin n_fail++; $display("FAIL perr_ack got=%b exp=00", ack); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL perr_count got=%0d exp=0", count); end
        send = 2'b00;
        for (int i = 0; i < 4; i++) tick();
        n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky got=%b exp=1", proto_err); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        dado_ready = 1'b0;
        send_item(2'd1, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_xfer0 got=timeout exp=ack"); end
        send_item(2'd2, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_xfer1 got=timeout exp=ack"); end
        dadoT = 2'd3; send = 2'b01;
        n = 0;
        do begin tick(); n++; end while (ack !== 2'b01 && n < 20);
        n_tests++; if (ack !== 2'b01 || count !== 3'd3) begin
            n_fail++; $display("FAIL rst_pre got=ack%b/cnt%0d exp=ack01/cnt3", ack, count);
        end
        #2 reset = 1'b0;
        #1;
        n_tests++; if (ack !== 2'b00)       begin n_fail++; $display("FAIL rst_async_ack got=%b exp=00", ack); end
        n_tests++; if (count !== 3'd0)      begin n_fail++; $display("FAIL rst_async_count got=%0d exp=0", count); end
        n_tests++; if (dado_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got=%b exp=0", dado_valid); end
        n_tests++; if (proto_err !== 1'b0)  begin n_fail++; $display("FAIL rst_async_perr got=%b exp=0", proto_err); end
        tick();
        reset = 1'b1;
        tick(); tick();
        n_tests++; if (ack !== 2'b00) begin n_fail++; $display("FAIL rst_recap_early got=%b exp=00", ack); end
        tick();
        n_tests++; if (ack !== 2'b01)     begin n_fail++; $display("FAIL rst_recap_ack got=%b exp=01", ack); end
        n_tests++; if (count !== 3'd1)    begin n_fail++; $display("FAIL rst_recap_count got=%0d exp=1", count); end
        n_tests++; if (dado_out !== 2'd3) begin n_fail++; $display("FAIL rst_recap_dout got=%0d exp=3", dado_out); end
        send = 2'b00;
        n = 0;
        do begin tick(); n++; end while (ack !== 2'b00 && n < 20);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_streaming();
        test_push_pop();
        test_proto_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_periph_rx_buffer
